// File: rtl/select_wakeup_pipeline_pkg.sv
// rtl/select_wakeup_pipeline_pkg.sv - shared scheduler types and pipeline constants
package SchedulerTypes;

  localparam int ISSUE_WIDTH  = 4;
  localparam int WAKEUP_WIDTH = 3;
  localparam int ENTRY_NUM    = 16;
  localparam int IDX_W        = $clog2(ENTRY_NUM);
  localparam int WAKEUP_LAT   = 1;
  localparam int RELEASE_LAT  = 2;
  localparam int INFLIGHT_W   = $clog2(ISSUE_WIDTH * RELEASE_LAT + 1);

  typedef logic [IDX_W-1:0]     IssueQueueIndexPath;
  typedef logic [ENTRY_NUM-1:0] IssueQueueOneHotPath;

  typedef struct packed {
    logic                valid;
    IssueQueueIndexPath  ptr;
    IssueQueueOneHotPath vec;
  } WakeupStageEntry;

  function automatic IssueQueueOneHotPath idx_to_onehot(input IssueQueueIndexPath p);
    return IssueQueueOneHotPath'(1) << p;
  endfunction

endpackage

// File: rtl/select_wakeup_pipeline_lane_pipe.sv
// rtl/select_wakeup_pipeline_lane_pipe.sv - one issue lane's stage chain (WAKEUP_CANCEL_EN adds cancel)
module wakeup_lane_pipe
  import SchedulerTypes::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   sel_valid_i,
  input  IssueQueueIndexPath     sel_ptr_i,
  input  IssueQueueOneHotPath    sel_vec_i,
`ifdef WAKEUP_CANCEL_EN
  input  IssueQueueOneHotPath    cancel_vec_i,
`endif
  output logic                   wk_fire_o,
  output IssueQueueIndexPath     wk_ptr_o,
  output IssueQueueOneHotPath    wk_vec_o,
  output logic                   rl_fire_o,
  output IssueQueueIndexPath     rl_ptr_o,
  output logic [RELEASE_LAT-1:0] valid_d_o
);

  WakeupStageEntry [RELEASE_LAT-1:0] s_q, s_d;
  logic            [RELEASE_LAT-1:0] kill;

  always_comb begin
    kill = '0;
`ifdef WAKEUP_CANCEL_EN
    for (int k = 0; k < RELEASE_LAT; k++) begin
      kill[k] = s_q[k].valid & (|(s_q[k].vec & cancel_vec_i));
    end
`endif
    s_d = s_q;
    for (int k = 0; k < RELEASE_LAT; k++) begin
      s_d[k].valid = s_q[k].valid & ~kill[k];
    end
    if (!stall_i) begin
      s_d[0].valid = sel_valid_i;
      s_d[0].ptr   = sel_ptr_i;
      s_d[0].vec   = sel_vec_i;
      for (int k = 1; k < RELEASE_LAT; k++) begin
        s_d[k]       = s_q[k-1];
        s_d[k].valid = s_q[k-1].valid & ~kill[k-1];
      end
    end
    // Flush wins over both hold and capture.
    if (flush_i) begin
      for (int k = 0; k < RELEASE_LAT; k++) begin
        s_d[k].valid = 1'b0;
      end
    end
    for (int k = 0; k < RELEASE_LAT; k++) begin
      valid_d_o[k] = s_d[k].valid;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  // Outputs are gated by stall so a held stage never re-fires.
  assign wk_fire_o = s_q[WAKEUP_LAT-1].valid & ~stall_i;
  assign wk_ptr_o  = s_q[WAKEUP_LAT-1].ptr;
  assign wk_vec_o  = wk_fire_o ? s_q[WAKEUP_LAT-1].vec : '0;
  assign rl_fire_o = s_q[RELEASE_LAT-1].valid & ~stall_i;
  assign rl_ptr_o  = s_q[RELEASE_LAT-1].ptr;

`ifndef WAKEUP_CANCEL_EN
  logic unused_tail_vec;
  assign unused_tail_vec = ^s_q[RELEASE_LAT-1].vec;
`endif

endmodule

// File: rtl/select_wakeup_pipeline.sv
// rtl/select_wakeup_pipeline.sv - select-to-wakeup/release delay pipeline (WAKEUP_CANCEL_EN adds cancelVector)
module select_wakeup_pipeline
  import SchedulerTypes::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      stall,
  input  logic                                      flush,
  input  logic [ISSUE_WIDTH-1:0]                    selected,
  input  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         selectedPtr,
  input  logic [ISSUE_WIDTH-1:0][ENTRY_NUM-1:0]     selectedVector,
`ifdef WAKEUP_CANCEL_EN
  input  logic [ENTRY_NUM-1:0]                      cancelVector,
`endif
  output logic [WAKEUP_WIDTH-1:0]                   wakeup,
  output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         wakeupPtr,
  output logic [ISSUE_WIDTH-1:0][ENTRY_NUM-1:0]     wakeupVector,
  output logic [ISSUE_WIDTH-1:0]                    releaseEntry,
  output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]         releasePtr,
  output logic [INFLIGHT_W-1:0]                     inFlight
);

  logic [ISSUE_WIDTH-1:0]                  wk_fire;
  logic [ISSUE_WIDTH-1:0][RELEASE_LAT-1:0] valid_d;
  logic [INFLIGHT_W-1:0]                   in_flight_d, in_flight_q;

  for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_lane
    wakeup_lane_pipe u_lane (
      .clk_i        (clk),
      .rst_ni       (rst),
      .stall_i      (stall),
      .flush_i      (flush),
      .sel_valid_i  (selected[l] & ~flush),
      .sel_ptr_i    (selectedPtr[l]),
      .sel_vec_i    (selectedVector[l]),
`ifdef WAKEUP_CANCEL_EN
      .cancel_vec_i (cancelVector),
`endif
      .wk_fire_o    (wk_fire[l]),
      .wk_ptr_o     (wakeupPtr[l]),
      .wk_vec_o     (wakeupVector[l]),
      .rl_fire_o    (releaseEntry[l]),
      .rl_ptr_o     (releasePtr[l]),
      .valid_d_o    (valid_d[l])
    );
  end

  // Lanes above WAKEUP_WIDTH still carry ptr/vector but never raise wakeup.
  assign wakeup = wk_fire[WAKEUP_WIDTH-1:0];
  if (WAKEUP_WIDTH < ISSUE_WIDTH) begin : g_no_wake
    logic unused_wk_fire;
    assign unused_wk_fire = ^wk_fire[ISSUE_WIDTH-1:WAKEUP_WIDTH];
  end

  always_comb begin
    in_flight_d = '0;
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      for (int k = 0; k < RELEASE_LAT; k++) begin
        in_flight_d = in_flight_d + INFLIGHT_W'(valid_d[l][k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight_q <= '0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  assign inFlight = in_flight_q;

  always @(posedge clk) begin
    if (rst) begin
      assert (RELEASE_LAT >= WAKEUP_LAT) else $error("RELEASE_LAT below WAKEUP_LAT");
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (selected[l]) begin
          assert (selectedVector[l] == idx_to_onehot(selectedPtr[l]))
            else $error("selectedVector lane %0d not one-hot of selectedPtr", l);
        end
      end
      for (int a = 0; a < ISSUE_WIDTH; a++) begin
        for (int b = a + 1; b < ISSUE_WIDTH; b++) begin
          assert (!(selected[a] && selected[b] && selectedPtr[a] == selectedPtr[b]))
            else $error("entry selected on lanes %0d and %0d", a, b);
        end
      end
    end
  end

endmodule

// File: tb/tb_select_wakeup_pipeline.sv
// tb/tb_select_wakeup_pipeline.sv - scoreboard bench for select_wakeup_pipeline
module tb_select_wakeup_pipeline;
  import SchedulerTypes::*;

  logic                                  clk = 1'b0;
  logic                                  rst = 1'b0;
  logic                                  stall, flush;
  logic [ISSUE_WIDTH-1:0]                selected;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     selectedPtr;
  logic [ISSUE_WIDTH-1:0][ENTRY_NUM-1:0] selectedVector;
  logic [ENTRY_NUM-1:0]                  cancelVector;
  logic [WAKEUP_WIDTH-1:0]               wakeup;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     wakeupPtr;
  logic [ISSUE_WIDTH-1:0][ENTRY_NUM-1:0] wakeupVector;
  logic [ISSUE_WIDTH-1:0]                releaseEntry;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     releasePtr;
  logic [INFLIGHT_W-1:0]                 inFlight;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] wake_q[$];
  logic [63:0] rel_q[$];

  select_wakeup_pipeline dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .selected       (selected),
    .selectedPtr    (selectedPtr),
    .selectedVector (selectedVector),
`ifdef WAKEUP_CANCEL_EN
    .cancelVector   (cancelVector),
`endif
    .wakeup         (wakeup),
    .wakeupPtr      (wakeupPtr),
    .wakeupVector   (wakeupVector),
    .releaseEntry   (releaseEntry),
    .releasePtr     (releasePtr),
    .inFlight       (inFlight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Event key: cycle, kind (1 wakeup, 2 vector-only lane, 3 release), lane, ptr.
  function automatic logic [63:0] ev(input int c, input int kind, input int lane, input int ptr);
    return (64'(c) << 12) | (64'(kind) << 8) | (64'(lane) << 4) | 64'(ptr);
  endfunction

  task automatic idle();
    stall = 1'b0;
    flush = 1'b0;
    selected = '0;
    selectedPtr = '0;
    selectedVector = '0;
    cancelVector = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sel(input int lane, input int ptr);
    logic [ENTRY_NUM-1:0] one;
    one = 1;
    selected[lane] = 1'b1;
    selectedPtr[lane] = IDX_W'(ptr);
    selectedVector[lane] = one << ptr;
  endtask

  task automatic chk_inflight(input string tag, input int exp);
    @(negedge clk);
    chk(tag, 64'(inFlight), 64'(exp));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      logic [ISSUE_WIDTH-1:0] wk4;
      logic [63:0] obs;
      logic [ENTRY_NUM-1:0] one;
      one = 1;
      wk4 = ISSUE_WIDTH'(wakeup);
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (wk4[l] || wakeupVector[l] != '0) begin
          obs = ev(cyc, wk4[l] ? 1 : 2, l, int'(wakeupPtr[l]));
          if (wake_q.size() == 0) chk("wake_unexpected", obs, 64'd0);
          else chk("wake_event", obs, wake_q.pop_front());
          chk("wake_vector", 64'(wakeupVector[l]), 64'(one << wakeupPtr[l]));
        end
      end
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (releaseEntry[l]) begin
          obs = ev(cyc, 3, l, int'(releasePtr[l]));
          if (rel_q.size() == 0) chk("release_unexpected", obs, 64'd0);
          else chk("release_event", obs, rel_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    idle();
    #12;
    chk("reset_outputs", {wakeup, releaseEntry, wakeupVector}, 64'd0);
    chk("reset_inflight", 64'(inFlight), 64'd0);
    tick();
    rst = 1'b1;

    // Reset mid-traffic: wakeup at T+1 seen, then async reset drops everything.
    tick();
    sel(0, 2); sel(1, 6); t = cyc;
    wake_q.push_back(ev(t + 1, 1, 0, 2));
    wake_q.push_back(ev(t + 1, 1, 1, 6));
    tick();
    @(negedge clk);
    chk("pre_reset_inflight", 64'(inFlight), 64'd2);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {wakeup, releaseEntry, wakeupVector}, 64'd0);
    chk("async_reset_ptrs", {wakeupPtr, releasePtr}, 64'd0);
    chk("async_reset_inflight", 64'(inFlight), 64'd0);
    tick();
    rst = 1'b1;

    // Single select after reset release.
    tick();
    sel(0, 5); t = cyc;
    wake_q.push_back(ev(t + 1, 1, 0, 5));
    rel_q.push_back(ev(t + 2, 3, 0, 5));
    tick();
    chk_inflight("single_inflight", 1);
    tick(); tick(); tick();

    // Full width: lane 3 carries vector only.
    sel(0, 1); sel(1, 2); sel(2, 3); sel(3, 4); t = cyc;
    for (int l = 0; l < ISSUE_WIDTH; l++)
      wake_q.push_back(ev(t + 1, l < WAKEUP_WIDTH ? 1 : 2, l, l + 1));
    for (int l = 0; l < ISSUE_WIDTH; l++)
      rel_q.push_back(ev(t + 2, 3, l, l + 1));
    tick();
    chk_inflight("full_inflight_t1", 4);
    tick();
    chk_inflight("full_inflight_t2", 4);
    tick();
    chk_inflight("full_inflight_t3", 0);
    tick(); tick();

    // Stall T+1..T+3: single wakeup at T+4, release at T+5.
    sel(0, 7); t = cyc;
    wake_q.push_back(ev(t + 4, 1, 0, 7));
    rel_q.push_back(ev(t + 5, 3, 0, 7));
    for (int i = 1; i <= 3; i++) begin
      tick();
      stall = 1'b1;
      chk_inflight("stall_inflight", 1);
    end
    tick(); tick(); tick(); tick();

    // Flush with stall and a new select: nothing survives.
    sel(0, 9);
    tick();
    flush = 1'b1; stall = 1'b1; sel(0, 10);
    tick();
    chk_inflight("flush_inflight", 0);
    tick(); tick(); tick();

    // Cancel: wakeup at T+1 still fires, release depends on build.
    sel(0, 3); t = cyc;
    wake_q.push_back(ev(t + 1, 1, 0, 3));
`ifndef WAKEUP_CANCEL_EN
    rel_q.push_back(ev(t + 2, 3, 0, 3));
`endif
    tick();
    cancelVector = 16'h0008;
    tick(); tick(); tick();

    // Back-to-back on lane 0.
    t = cyc;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      wake_q.push_back(ev(t + i + 1, 1, 0, i));
      rel_q.push_back(ev(t + i + 2, 3, 0, i));
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      sel(0, i);
      if (i >= 2) chk_inflight("b2b_inflight", 2);
      if (i < ENTRY_NUM - 1) tick();
    end
    tick(); tick(); tick(); tick();

    chk("wake_queue_drained", 64'(wake_q.size()), 64'd0);
    chk("release_queue_drained", 64'(rel_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
